// File: rtl/vs_codec_responder.sv
// VS10xx-style decoder endpoint: SCI register commands, SDI audio bytes into a FWFT FIFO,
// DREQ flow control. SPI pins are oversampled on CLK, so SCLK must run at CLK/8 or slower.
module vs_codec_responder #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned DREQ_FREE  = 32,
  parameter int unsigned RESET_DLY  = 1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        XRESET_N,
  input  logic        SPI_SCLK,
  input  logic        SPI_CS_N,
  input  logic        SPI_DCS_N,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        DREQ,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  output logic [15:0] SCI_MODE,
  output logic [15:0] SCI_VOL,
  output logic        CMD_ERR,
  output logic        OVF
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(RESET_DLY + 1);
  localparam logic [LW-1:0] LvlFull    = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LvlDreqMax = LW'(FIFO_DEPTH - DREQ_FREE);
  localparam logic [CW-1:0] DlyDone    = CW'(RESET_DLY);
  localparam logic [7:0]    OpWrite    = 8'h02;
  localparam logic [7:0]    OpRead     = 8'h03;
  localparam logic [15:0]   ModeDflt   = 16'h0800;

  typedef enum logic [1:0] {StIdle, StOpcode, StAddr, StData} sci_state_e;

  logic [1:0] sclk_sync_q, cs_sync_q, dcs_sync_q, mosi_sync_q, xrst_sync_q;
  logic       sclk_prev_q, cs_prev_q;

  sci_state_e state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [30:0] shift_q, shift_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        is_read_q, is_read_d;
  logic        collide_q, collide_d;
  logic        miso_q, miso_d;
  logic        cmd_err_q, cmd_err_d;
  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  logic [6:0]  sdi_shift_q, sdi_shift_d;
  logic [2:0]  sdi_cnt_q, sdi_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] dly_cnt_q, dly_cnt_d;
  logic          dreq_q, dreq_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic sclk_s, cs_s, dcs_s, mosi_s, hard_rst;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, frame_active, sdi_active;
  logic [31:0] sci_word;
  logic [3:0]  sci_addr;
  logic [7:0]  sdi_byte;
  logic wr_ok, rd_ok, soft_rst, push, pop, wr_en, fifo_full;

  // Synchronizers reset to the idle pin levels so no false edges follow RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      dcs_sync_q  <= 2'b11;
      mosi_sync_q <= 2'b00;
      xrst_sync_q <= 2'b11;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], SPI_SCLK};
      cs_sync_q   <= {cs_sync_q[0], SPI_CS_N};
      dcs_sync_q  <= {dcs_sync_q[0], SPI_DCS_N};
      mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
      xrst_sync_q <= {xrst_sync_q[0], XRESET_N};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  assign sclk_s       = sclk_sync_q[1];
  assign cs_s         = cs_sync_q[1];
  assign dcs_s        = dcs_sync_q[1];
  assign mosi_s       = mosi_sync_q[1];
  assign hard_rst     = ~xrst_sync_q[1];
  assign sclk_rise    = sclk_s & ~sclk_prev_q;
  assign sclk_fall    = ~sclk_s & sclk_prev_q;
  assign cs_fall      = cs_prev_q & ~cs_s;
  assign cs_rise      = ~cs_prev_q & cs_s;
  assign frame_active = (state_q != StIdle);
  assign sdi_active   = ~dcs_s & cs_s;
  assign sci_word     = {shift_q, mosi_s};
  assign sci_addr     = sci_word[19:16];
  assign sdi_byte     = {sdi_shift_q, mosi_s};
  assign wr_ok        = (sci_word[31:24] == OpWrite) && (sci_word[23:20] == 4'h0);
  assign rd_ok        = (sci_word[31:24] == OpRead);
  assign fifo_full    = (level_q == LvlFull);
  assign pop          = DATA_VALID & DATA_READY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (hard_rst) begin
      state_d = StIdle;
    end else if (cs_fall) begin
      state_d = StOpcode;
    end else if (frame_active && cs_rise) begin
      state_d = StIdle;
    end else if (sclk_rise) begin
      case (state_q)
        StOpcode: if (bit_cnt_q == 5'd7)  state_d = StAddr;
        StAddr:   if (bit_cnt_q == 5'd15) state_d = StData;
        StData:   if (bit_cnt_q == 5'd31) state_d = StIdle;
        default:  ;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rd_data_d   = rd_data_q;
    is_read_d   = is_read_q;
    collide_d   = collide_q;
    miso_d      = miso_q;
    cmd_err_d   = 1'b0;
    regs_d      = regs_q;
    soft_rst    = 1'b0;
    sdi_shift_d = sdi_shift_q;
    sdi_cnt_d   = sdi_cnt_q;
    push        = 1'b0;

    if (cs_fall) begin
      bit_cnt_d = '0;
      collide_d = 1'b0;
      is_read_d = 1'b0;
    end else if (frame_active && cs_rise) begin
      cmd_err_d = 1'b1;
    end else if (frame_active) begin
      if (!dcs_s) collide_d = 1'b1;
      if (sclk_rise) begin
        shift_d   = sci_word[30:0];
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd15) begin
          is_read_d = (sci_word[15:8] == OpRead);
          rd_data_d = (sci_word[7:4] == 4'h0) ? regs_q[sci_word[3:0]] : 16'h0000;
        end
        if (bit_cnt_q == 5'd31) begin
          if (wr_ok) begin
            regs_d[sci_addr] = sci_word[15:0];
            // MODE bit 2 is a self-clearing soft reset request.
            if (sci_addr == 4'h0 && sci_word[2]) begin
              regs_d[0][2] = 1'b0;
              soft_rst     = 1'b1;
            end
          end
          cmd_err_d = collide_d || !(wr_ok || rd_ok);
        end
      end
      if (sclk_fall && state_q == StData && is_read_q) begin
        miso_d    = rd_data_q[15];
        rd_data_d = {rd_data_q[14:0], 1'b0};
      end
    end
    if (state_d != StData) miso_d = 1'b0;

    if (!sdi_active) begin
      sdi_cnt_d = '0;
    end else if (sclk_rise) begin
      sdi_shift_d = sdi_byte[6:0];
      sdi_cnt_d   = sdi_cnt_q + 3'd1;
      push        = (sdi_cnt_q == 3'd7);
    end

    wr_en    = push && (!fifo_full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push && !wr_en) ovf_d = 1'b1;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !pop)      level_d = level_q + LW'(1);
    else if (!wr_en && pop) level_d = level_q - LW'(1);

    dly_cnt_d = dly_cnt_q;
    if (dly_cnt_q != DlyDone) dly_cnt_d = dly_cnt_q + CW'(1);

    if (soft_rst) begin
      wr_en     = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      ovf_d     = 1'b0;
      dly_cnt_d = '0;
    end

    if (hard_rst) begin
      bit_cnt_d = '0;
      rd_data_d = '0;
      is_read_d = 1'b0;
      collide_d = 1'b0;
      miso_d    = 1'b0;
      cmd_err_d = 1'b0;
      for (int i = 0; i < 16; i++) regs_d[i] = 16'h0000;
      regs_d[0] = ModeDflt;
      sdi_cnt_d = '0;
      wr_en     = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      ovf_d     = 1'b0;
      dly_cnt_d = '0;
    end

    dreq_d = !hard_rst && (dly_cnt_d == DlyDone) && (level_d <= LvlDreqMax);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rd_data_q   <= '0;
      is_read_q   <= 1'b0;
      collide_q   <= 1'b0;
      miso_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= (i == 0) ? ModeDflt : 16'h0000;
      sdi_shift_q <= '0;
      sdi_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      dly_cnt_q   <= '0;
      dreq_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rd_data_q   <= rd_data_d;
      is_read_q   <= is_read_d;
      collide_q   <= collide_d;
      miso_q      <= miso_d;
      cmd_err_q   <= cmd_err_d;
      regs_q      <= regs_d;
      sdi_shift_q <= sdi_shift_d;
      sdi_cnt_q   <= sdi_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      dly_cnt_q   <= dly_cnt_d;
      dreq_q      <= dreq_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_q] <= sdi_byte;
  end

  assign DATA_OUT   = mem[rd_ptr_q];
  assign DATA_VALID = (level_q != '0);
  assign SPI_MISO   = miso_q;
  assign DREQ       = dreq_q;
  assign SCI_MODE   = regs_q[0];
  assign SCI_VOL    = regs_q[11];
  assign CMD_ERR    = cmd_err_q;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_vs_codec_responder.sv
// Randomized scoreboard bench for vs_codec_responder: a queue models the audio FIFO and an
// array models the SCI register file; a negedge monitor checks every popped byte.
module tb_vs_codec_responder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        XRESET_N = 1'b1;
  logic        SPI_SCLK = 1'b0;
  logic        SPI_CS_N = 1'b1;
  logic        SPI_DCS_N = 1'b1;
  logic        SPI_MOSI = 1'b0;
  logic        DATA_READY = 1'b0;
  logic        SPI_MISO, DREQ, DATA_VALID, CMD_ERR, OVF;
  logic [7:0]  DATA_OUT;
  logic [15:0] SCI_MODE, SCI_VOL;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int err_exp = 0;
  bit drain_chk = 1'b0;
  logic [7:0]  exp_q[$];
  logic [15:0] mdl_regs [16];
  logic        mdl_ovf = 1'b0;

  vs_codec_responder dut (
    .CLK(CLK), .RESET(RESET), .XRESET_N(XRESET_N), .SPI_SCLK(SPI_SCLK),
    .SPI_CS_N(SPI_CS_N), .SPI_DCS_N(SPI_DCS_N), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .DREQ(DREQ), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .SCI_MODE(SCI_MODE), .SCI_VOL(SCI_VOL), .CMD_ERR(CMD_ERR), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops the expected queue whenever the DUT hands out a byte.
  always @(negedge CLK) begin
    if (drain_chk) begin
      check("drain_dreq", DREQ, (exp_q.size() <= 32));
      check("drain_valid", DATA_VALID, (exp_q.size() != 0));
    end
    if (DATA_VALID && DATA_READY) begin
      if (exp_q.size() == 0) check("unexpected_byte", DATA_OUT, 32'hFFFF_FFFF);
      else check("fifo_byte", DATA_OUT, exp_q.pop_front());
    end
    if (CMD_ERR) err_seen++;
  end

  initial begin
    repeat (95000) @(posedge CLK);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    SPI_MOSI = b;
    tick(5);
    m = SPI_MISO;
    SPI_SCLK = 1'b1;
    tick(5);
    SPI_SCLK = 1'b0;
  endtask

  task automatic sci_frame(input logic [31:0] w, input int nbits, input logic with_dcs,
                           output logic [31:0] rx);
    logic m;
    rx = '0;
    SPI_CS_N = 1'b0;
    if (with_dcs) SPI_DCS_N = 1'b0;
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(w[31-i], m);
      rx[31-i] = m;
    end
    tick(5);
    SPI_DCS_N = 1'b1;
    SPI_CS_N  = 1'b1;
    tick(10);
  endtask

  task automatic mdl_push(input logic [7:0] b);
    if (exp_q.size() < 64) exp_q.push_back(b);
    else mdl_ovf = 1'b1;
  endtask

  task automatic sdi_send(input int n, input logic [7:0] fixed [$]);
    logic m;
    logic [7:0] b;
    SPI_DCS_N = 1'b0;
    tick(5);
    for (int k = 0; k < n; k++) begin
      b = (k < fixed.size()) ? fixed[k] : 8'($urandom);
      for (int i = 7; i >= 0; i--) spi_bit(b[i], m);
      mdl_push(b);
    end
    tick(5);
    SPI_DCS_N = 1'b1;
    tick(5);
  endtask

  task automatic drain(input bit random_ready);
    int n = 0;
    drain_chk = 1'b1;
    while (exp_q.size() != 0 && n < 3000) begin
      DATA_READY = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(1);
      n++;
    end
    DATA_READY = 1'b0;
    drain_chk  = 1'b0;
    check("drain_left", exp_q.size(), 0);
    tick(2);
    check("drained_valid", DATA_VALID, 1'b0);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_mode"}, SCI_MODE, mdl_regs[0]);
    check({tag, "_vol"}, SCI_VOL, mdl_regs[11]);
    check({tag, "_errs"}, err_seen, err_exp);
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl_regs[i] = 16'h0000;
    mdl_regs[0] = 16'h0800;
    exp_q.delete();
    mdl_ovf = 1'b0;
  endtask

  initial begin
    logic [31:0] rx;
    logic [7:0]  none [$];
    logic [7:0]  words [$];
    logic m;
    int n;
    int sel;
    logic [7:0]  op, addr;
    logic [15:0] data;

    mdl_reset();
    tick(3);
    check("rst_dreq", DREQ, 1'b0);
    check("rst_valid", DATA_VALID, 1'b0);
    check("rst_ovf", OVF, 1'b0);
    check("rst_miso", SPI_MISO, 1'b0);
    check_regs("rst");

    @(negedge CLK);
    RESET = 1'b0;
    repeat (999) @(posedge CLK);
    #1 check("dly_999", DREQ, 1'b0);
    @(posedge CLK);
    #1 check("dly_1000", DREQ, 1'b1);

    sci_frame(32'h020B2020, 32, 1'b0, rx);
    mdl_regs[11] = 16'h2020;
    check_regs("wr_vol");

    sci_frame(32'h030B0000, 32, 1'b0, rx);
    check("rd_vol", rx, {16'h0000, mdl_regs[11]});
    sci_frame(32'h03000000, 32, 1'b0, rx);
    check("rd_mode", rx, {16'h0000, mdl_regs[0]});

    sci_frame(32'h020B7777, 20, 1'b0, rx);
    err_exp++;
    check_regs("abort");
    sci_frame(32'h020B1010, 32, 1'b0, rx);
    mdl_regs[11] = 16'h1010;
    check_regs("wr_after_abort");

    sci_frame(32'h05011234, 32, 1'b0, rx);
    err_exp++;
    check_regs("bad_op");
    sci_frame(32'h02101234, 32, 1'b0, rx);
    err_exp++;
    check_regs("bad_addr");
    sci_frame(32'h020B3333, 32, 1'b1, rx);
    mdl_regs[11] = 16'h3333;
    err_exp++;
    check_regs("collide");
    check("collide_fifo", DATA_VALID, 1'b0);

    words = '{8'hA5, 8'h5A, 8'h12, 8'h34};
    sdi_send(4, words);
    check("sdi_head_valid", DATA_VALID, 1'b1);
    check("sdi_head", DATA_OUT, 8'hA5);
    SPI_DCS_N = 1'b0;
    tick(5);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    tick(5);
    SPI_DCS_N = 1'b1;
    tick(5);
    sdi_send(28, none);
    check("lvl32_dreq", DREQ, 1'b1);
    sdi_send(1, none);
    check("lvl33_dreq", DREQ, 1'b0);
    sdi_send(32, none);
    check("full_ovf", OVF, mdl_ovf);
    check("full_ovf_set", mdl_ovf, 1'b1);
    drain(1'b0);
    check("ovf_sticky", OVF, 1'b1);
    check("drained_dreq", DREQ, 1'b1);

    sdi_send(5, none);
    check("pre_srst_valid", DATA_VALID, 1'b1);
    fork
      sci_frame(32'h02000804, 32, 1'b0, rx);
      begin
        n = 0;
        do begin
          @(posedge CLK);
          #1;
          n++;
        end while (DATA_VALID && n < 2000);
        check("srst_flush", DATA_VALID, 1'b0);
        exp_q.delete();
        mdl_ovf = 1'b0;
        repeat (999) @(posedge CLK);
        #1 check("srst_dly_999", DREQ, 1'b0);
        @(posedge CLK);
        #1 check("srst_dly_1000", DREQ, 1'b1);
      end
    join
    mdl_regs[0] = 16'h0800;
    check_regs("srst");
    check("srst_ovf", OVF, 1'b0);

    for (int t = 0; t < 24; t++) begin
      sel  = $urandom_range(0, 3);
      data = 16'($urandom);
      if (sel == 0) begin
        addr = 8'($urandom_range(0, 15));
        if (addr == 8'h00) data[2] = 1'b0;
        sci_frame({8'h02, addr, data}, 32, 1'b0, rx);
        mdl_regs[addr[3:0]] = data;
      end else if (sel == 1) begin
        addr = 8'($urandom_range(0, 15));
        sci_frame({8'h03, addr, data}, 32, 1'b0, rx);
        check("rand_read", rx, {16'h0000, mdl_regs[addr[3:0]]});
      end else if (sel == 2) begin
        op = 8'($urandom_range(4, 255));
        sci_frame({op, 8'h0B, data}, 32, 1'b0, rx);
        err_exp++;
      end else begin
        addr = 8'($urandom_range(16, 255));
        sci_frame({8'h02, addr, data}, 32, 1'b0, rx);
        err_exp++;
      end
      check_regs("rand_sci");
    end

    for (int t = 0; t < 3; t++) begin
      sdi_send($urandom_range(1, 40), none);
      check("batch_dreq", DREQ, (exp_q.size() <= 32));
      drain(1'b1);
    end

    sci_frame(32'h020B4242, 32, 1'b0, rx);
    mdl_regs[11] = 16'h4242;
    check_regs("pre_xrst");
    sdi_send(3, none);
    XRESET_N = 1'b0;
    tick(10);
    mdl_reset();
    check_regs("xrst_held");
    check("xrst_valid", DATA_VALID, 1'b0);
    check("xrst_dreq", DREQ, 1'b0);
    XRESET_N = 1'b1;
    tick(990);
    check("xrst_dly_low", DREQ, 1'b0);
    n = 0;
    while (!DREQ && n < 30) begin
      tick(1);
      n++;
    end
    check("xrst_dly_high", DREQ, 1'b1);
    check_regs("post_xrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vs_codec_responder.md
Name: vs_codec_responder

Overview:
- Behavioural/synthesizable model of the VS10xx decoder end of the MP3 player's serial link. It is the responder to the existing MP3 streaming master.
- Decodes SCI register commands (framed by SPI_CS_N) and SDI audio bytes (framed by SPI_DCS_N).
- Buffers audio bytes in a FIFO, drives DREQ flow control, and exposes the volume and mode registers.
- Used as the device-under-link in MP3 top-level simulation, or on a second board as a loopback target.

Parameters:
- FIFO_DEPTH, 64, audio byte FIFO depth (power of 2).
- DREQ_FREE, 32, minimum free FIFO bytes for DREQ=1.
- RESET_DLY, 1000, CLK cycles DREQ stays low after any reset.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- XRESET_N  in  1  device hardware reset from master, active low, asynchronous pin (synchronized internally).
- SPI_SCLK  in  1  serial clock from master, at most CLK/8.
- SPI_CS_N  in  1  SCI frame select, active low.
- SPI_DCS_N  in  1  SDI frame select, active low.
- SPI_MOSI  in  1  serial data in, MSB first.
- SPI_MISO  out  1  SCI read data.
- DREQ  out  1  ready for 32 more bytes / next SCI command.
- DATA_OUT  out  8  FIFO head byte (first-word-fall-through).
- DATA_VALID  out  1  FIFO not empty.
- DATA_READY  in  1  consumer pops head when DATA_VALID&DATA_READY.
- SCI_MODE  out  16  register 0x0.
- SCI_VOL  out  16  register 0xB.
- CMD_ERR  out  1  one-cycle pulse on a malformed SCI frame.
- OVF  out  1  sticky FIFO overflow flag.

Behaviour:
- Input sync: SPI_SCLK, SPI_CS_N, SPI_DCS_N, SPI_MOSI, XRESET_N each pass through 2 flops. SCLK rise/fall detected from the synchronized signal. MOSI is sampled on the detected rise (mode 0).
- Register file: 16 x 16-bit. Defaults: MODE=0x0800, all others 0x0000.
- Async RESET: registers to defaults, FIFO empty, FSM=IDLE, MISO=0, DREQ=0, CMD_ERR=0, OVF=0, delay counter=0.
- XRESET_N low (synchronized): same effect as RESET, held while low.
- Reset delay: after RESET/XRESET_N release, DREQ rises exactly RESET_DLY cycles later, provided the FIFO free condition holds.
- DREQ (registered) = delay expired AND (FIFO_DEPTH - level) >= DREQ_FREE.
- SCI FSM states: IDLE, OPCODE, ADDR, DATA.
  - CS_N falling -> OPCODE, bit count 0. Bits 0-7 = opcode, 8-15 = address, 16-31 = data.
  - Write (opcode 0x02): on the 32nd rise, address <= 0x0F writes reg[addr]. Any other address is ignored and pulses CMD_ERR.
  - Read (opcode 0x03): on each SCLK fall in the DATA phase, MISO = reg[addr] MSB first. The first bit appears on the fall after the 16th rise. MISO=0 outside a read data phase.
  - Other opcodes: frame is consumed, no write, CMD_ERR pulse at the 32nd bit.
  - After 32 bits the FSM waits in IDLE until CS_N rises.
  - CS_N rising before 32 bits: abort, no write, CMD_ERR pulse.
- Soft reset: a write to MODE with bit 2 set stores the value with bit 2 cleared, flushes the FIFO, and restarts the RESET_DLY count (DREQ=0). OVF is cleared.
- SDI path (active when DCS_N low and CS_N high): shifts MOSI MSB first. Every 8th rise pushes one byte; 16-bit words therefore arrive high byte first. DCS_N rising mid-byte discards the partial bits.
- CS_N and DCS_N both low: SCI takes priority, SDI bits are ignored, one CMD_ERR pulse per frame.
- FIFO:
  - Push occurs on the cycle the 8th rise is detected; DATA_VALID rises the next cycle.
  - Pop occurs on DATA_VALID & DATA_READY.
  - Push while full with no pop: byte dropped, OVF=1 (sticky).
  - Push and pop in the same cycle while full: both accepted, level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- SCLK activity while both selects are high is ignored.

Test Plan:
1. RESET pulse, XRESET_N=1, FIFO empty -> DREQ=0 for 1000 cycles then 1; SCI_MODE=0x0800, SCI_VOL=0x0000, OVF=0.
2. SCI frame 0x020B2020 -> SCI_VOL=0x2020 after the 32nd bit; CMD_ERR stays 0; no other register changes.
3. SCI frame 0x02000804 with 5 bytes in the FIFO -> SCI_MODE=0x0800, DATA_VALID=0 next cycle, DREQ=0 for 1000 cycles then 1.
4. After test 2, SCI frame 0x030B0000 -> MISO bits 16-31 sampled on rises read 0x2020; MISO=0 during bits 0-15.
5. SDI words 0xA55A, 0x1234 with DATA_READY=0 -> FIFO holds A5, 5A, 12, 34 in order.
   - Continue to 33 bytes -> DREQ=0.
   - Continue to 65 bytes -> OVF=1, 65th byte dropped.
   - Then DATA_READY=1 -> 64 bytes out in order, DREQ returns to 1 once level <= 32.
6. CS_N raised after 20 bits of 0x020B2020 -> SCI_VOL unchanged, exactly one CMD_ERR pulse. A later full 0x020B1010 -> SCI_VOL=0x1010.
